audio_loop_ctrl: RTL and testbench
==================================

Name: audio_loop_ctrl

Overview:
Parametrised record/playback controller for a single-port-pair audio BRAM.
- Records a stream of samples (UART RX or SPI ADC bytes) into sequential addresses and latches the take length.
- Replays the take at the sample-rate tick, once or looped.
- Sits between the sample sources, the dual-port BRAM, and the PWM/UART-TX consumers, replacing the free-running address counters.

Parameters:
- WIDTH, 8, sample width in bits.
- DEPTH, 40000, BRAM depth in samples.
- READ_LATENCY, 2, BRAM read latency in cycles (addr to data); legal values 1..4.
- ADDR_W, $clog2(DEPTH), address width (derived).
- LEN_W, $clog2(DEPTH+1), width of the length count (derived).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rec_start_in  input  1  pulse; begin recording at address 0
- play_start_in  input  1  pulse; begin playback at address 0
- stop_in  input  1  pulse; end the current record or play
- loop_in  input  1  level; playback wraps at the end of the take
- sample_in  input  WIDTH  sample to record
- sample_valid_in  input  1  sample_in valid, one cycle
- tick_in  input  1  playback rate strobe (e.g. 8 kHz), one cycle
- bram_wr_addr_out  output  ADDR_W  port-B write address
- bram_wr_data_out  output  WIDTH  port-B write data
- bram_we_out  output  1  port-B write enable
- bram_rd_addr_out  output  ADDR_W  port-A read address
- bram_rd_data_in  input  WIDTH  port-A read data
- sample_out  output  WIDTH  played sample, held until the next valid
- sample_valid_out  output  1  one-cycle strobe with sample_out
- state_out  output  2  0 IDLE, 1 RECORD, 2 PLAY
- length_out  output  LEN_W  samples in the last completed take
- full_out  output  1  level; the last take filled DEPTH
- done_out  output  1  one-cycle pulse when a record or play ends

Behaviour:
- Reset: state IDLE; all addresses 0; bram_we_out 0; sample_out 0; sample_valid_out 0; length_out 0; full_out 0; done_out 0; read pipeline flushed.
- IDLE:
  - rec_start_in: go to RECORD; wr_addr cleared to 0; full_out cleared.
  - Else play_start_in with length_out > 0: go to PLAY; rd_addr cleared to 0.
  - play_start_in with length_out = 0 is ignored.
- RECORD:
  - Each sample_valid_in: bram_we_out=1 on the same cycle (combinational from sample_valid_in and state); address = wr_addr; data = sample_in.
  - wr_addr increments the following cycle.
  - Write at address DEPTH-1: length_out=DEPTH, full_out=1, done_out pulse, go to IDLE.
  - stop_in: length_out = count of samples written, including a write on the same cycle; done_out pulse; go to IDLE.
  - rec_start_in while in RECORD restarts at address 0; the take is discarded.
- PLAY:
  - Each tick_in: issue a read at rd_addr into a READ_LATENCY-deep valid pipeline.
  - READ_LATENCY cycles later: sample_out is loaded from bram_rd_data_in and sample_valid_out pulses.
  - End of take (read issued at length_out-1): if loop_in, rd_addr wraps to 0 and PLAY continues; else go to IDLE with done_out pulsing on the same cycle.
  - Reads already in the pipeline still complete and emit after the state leaves PLAY.
  - stop_in: go to IDLE and pulse done_out; the in-flight pipeline is flushed, so no further sample_valid_out.
  - rec_start_in in PLAY: go to RECORD; the pipeline is flushed.
- Simultaneous events:
  - stop_in has priority over start inputs in the same cycle.
  - rec_start_in has priority over play_start_in.
  - tick_in and sample_valid_in are ignored in non-matching states.
- bram_rd_addr_out is rd_addr, registered. Ticks faster than READ_LATENCY are legal; the pipeline accepts one read per cycle.
- Reset mid-operation returns to the reset values. BRAM contents are untouched, but length_out=0, so the old take is unplayable.

Optional Feature:
- AUDIO_LOOP_VOLUME_EN defined:
  - Adds input port vol_in [2:0].
  - sample_out = bram_rd_data_in >> vol_in, logical shift, sampled at data capture.
  - vol_in=0 is pass-through.
- Undefined: no vol_in port; sample_out = bram_rd_data_in unmodified.

Decomposition:
- Package audio_loop_pkg:
  - typedef enum logic [1:0] {IDLE, RECORD, PLAY} state_t
  - localparam encodings matching state_out
- Sub-module audio_rd_pipe: READ_LATENCY-deep shift register of valid bits with synchronous flush; instantiated once.

Test Plan:
- DEPTH=8, READ_LATENCY=2. Record 5 samples 0x10..0x14 then stop_in -> writes at addresses 0..4, length_out=5, done_out one pulse, full_out=0.
- Record 9 samples with no stop -> writes at 0..7 only; on the 8th write length_out=8, full_out=1, state IDLE; the 9th sample produces no bram_we_out.
- Play the 5-sample take, loop_in=0, tick every 10 cycles -> sample_out 0x10..0x14, each valid 2 cycles after its tick; done_out with the 5th read; state IDLE.
- Same take with loop_in=1 and 12 ticks -> output sequence 0x10..0x14, 0x10..0x14, 0x10, 0x11; stop_in 1 cycle after a tick -> no valid for that tick.
- Same-cycle stop_in+rec_start_in in PLAY -> IDLE. rec_start_in+play_start_in in IDLE -> RECORD. rst_in mid-RECORD -> all outputs 0, length_out=0.
- With AUDIO_LOOP_VOLUME_EN, vol_in=2, stored 0xF0 -> sample_out 0x3C.

Source files
------------

// File: rtl/audio_loop_pkg.sv
// Shared state encodings for the audio record/playback controller.
// state_out reports these values directly, so the enum is pinned to them.
package audio_loop_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RECORD = 2'd1;
  localparam logic [1:0] ST_PLAY   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    RECORD = ST_RECORD,
    PLAY   = ST_PLAY
  } state_t;

endpackage

// File: rtl/audio_rd_pipe.sv
// Valid-bit shift register that tracks BRAM reads in flight.
// The output asserts LATENCY cycles after a push; a flush drops everything in flight.
module audio_rd_pipe #(
  parameter int LATENCY = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic flush_in,
  input  logic push_in,
  output logic valid_out
);

  logic [LATENCY-1:0] pipe_q;
  logic [LATENCY-1:0] pipe_d;

  // Flush wins over a push in the same cycle.
  always_comb begin
    pipe_d = '0;
    if (!flush_in) begin
      pipe_d[0] = push_in;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign valid_out = pipe_q[LATENCY-1];

endmodule

// File: rtl/audio_loop_ctrl.sv
// Record/playback controller for a dual-port audio BRAM: records a take, replays it once or looped.
// Define AUDIO_LOOP_VOLUME_EN to add vol_in, a right-shift attenuation applied to played samples.
module audio_loop_ctrl
  import audio_loop_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 40000,
  parameter int READ_LATENCY = 2,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int LEN_W        = $clog2(DEPTH + 1)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rec_start_in,
  input  logic              play_start_in,
  input  logic              stop_in,
  input  logic              loop_in,
  input  logic [WIDTH-1:0]  sample_in,
  input  logic              sample_valid_in,
  input  logic              tick_in,
`ifdef AUDIO_LOOP_VOLUME_EN
  input  logic [2:0]        vol_in,
`endif
  output logic [ADDR_W-1:0] bram_wr_addr_out,
  output logic [WIDTH-1:0]  bram_wr_data_out,
  output logic              bram_we_out,
  output logic [ADDR_W-1:0] bram_rd_addr_out,
  input  logic [WIDTH-1:0]  bram_rd_data_in,
  output logic [WIDTH-1:0]  sample_out,
  output logic              sample_valid_out,
  output logic [1:0]        state_out,
  output logic [LEN_W-1:0]  length_out,
  output logic              full_out,
  output logic              done_out
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [LEN_W-1:0]  FULL_LEN  = LEN_W'(DEPTH);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [LEN_W-1:0]   length_q, length_d;
  logic               full_q, full_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hold_q, hold_d;

  logic               wr_en;
  logic               issue;
  logic               flush;
  logic               capture;
  logic               end_of_take;
  logic [LEN_W-1:0]   written_len;
  logic [WIDTH-1:0]   rd_sample;

  assign wr_en       = (state_q == RECORD) && sample_valid_in;
  assign written_len = LEN_W'(wr_addr_q) + LEN_W'(wr_en);
  assign end_of_take = (LEN_W'(rd_addr_q) + LEN_W'(1)) == length_q;

  // Stop beats both starts, record beats play; done, state and length all update on the same edge.
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    length_d  = length_q;
    full_d    = full_q;
    done_d    = 1'b0;
    issue     = 1'b0;
    flush     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!stop_in && rec_start_in) begin
          state_d   = RECORD;
          wr_addr_d = '0;
          full_d    = 1'b0;
        end else if (!stop_in && play_start_in && (length_q != '0)) begin
          state_d   = PLAY;
          rd_addr_d = '0;
        end
      end
      RECORD: begin
        if (stop_in) begin
          state_d   = IDLE;
          length_d  = written_len;
          full_d    = wr_en && (wr_addr_q == LAST_ADDR);
          done_d    = 1'b1;
          wr_addr_d = '0;
        end else if (rec_start_in) begin
          wr_addr_d = '0;
          full_d    = 1'b0;
        end else if (wr_en) begin
          if (wr_addr_q == LAST_ADDR) begin
            state_d   = IDLE;
            length_d  = FULL_LEN;
            full_d    = 1'b1;
            done_d    = 1'b1;
            wr_addr_d = '0;
          end else begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
          end
        end
      end
      PLAY: begin
        if (stop_in) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          flush     = 1'b1;
          rd_addr_d = '0;
        end else if (rec_start_in) begin
          state_d   = RECORD;
          wr_addr_d = '0;
          full_d    = 1'b0;
          flush     = 1'b1;
          rd_addr_d = '0;
        end else if (tick_in) begin
          issue = 1'b1;
          if (end_of_take) begin
            rd_addr_d = '0;
            if (!loop_in) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  audio_rd_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .flush_in  (flush),
    .push_in   (issue),
    .valid_out (capture)
  );

`ifdef AUDIO_LOOP_VOLUME_EN
  assign rd_sample = bram_rd_data_in >> vol_in;
`else
  assign rd_sample = bram_rd_data_in;
`endif

  // The captured sample is shown in its strobe cycle and held in hold_q afterwards.
  always_comb begin
    hold_d = hold_q;
    if (capture) begin
      hold_d = rd_sample;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      length_q  <= '0;
      full_q    <= 1'b0;
      done_q    <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      length_q  <= length_d;
      full_q    <= full_d;
      done_q    <= done_d;
      hold_q    <= hold_d;
    end
  end

  assign bram_wr_addr_out = wr_addr_q;
  assign bram_wr_data_out = sample_in;
  assign bram_we_out      = wr_en;
  assign bram_rd_addr_out = rd_addr_q;
  assign sample_out       = capture ? rd_sample : hold_q;
  assign sample_valid_out = capture;
  assign state_out        = state_q;
  assign length_out       = length_q;
  assign full_out         = full_q;
  assign done_out         = done_q;

endmodule

// File: tb/tb_audio_loop_ctrl.sv
// Bench for audio_loop_ctrl at DEPTH=8, READ_LATENCY=2, with a reference model of takes and playback.
// Builds with or without AUDIO_LOOP_VOLUME_EN.
`timescale 1ns/1ps
module tb_audio_loop_ctrl;

  localparam int WIDTH        = 8;
  localparam int DEPTH        = 8;
  localparam int READ_LATENCY = 2;
  localparam int ADDR_W       = 3;
  localparam int LEN_W        = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              rec_start = 1'b0, play_start = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic              sample_valid = 1'b0, tick = 1'b0;
  logic [WIDTH-1:0]  sample = '0;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [WIDTH-1:0]  wr_data, rd_data, dut_sample;
  logic              we, dut_valid, full, done;
  logic [1:0]        state;
  logic [LEN_W-1:0]  length;
`ifdef AUDIO_LOOP_VOLUME_EN
  logic [2:0]        vol = 3'd0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  audio_loop_ctrl #(
    .WIDTH        (WIDTH),
    .DEPTH        (DEPTH),
    .READ_LATENCY (READ_LATENCY)
  ) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .rec_start_in     (rec_start),
    .play_start_in    (play_start),
    .stop_in          (stop),
    .loop_in          (loop_en),
    .sample_in        (sample),
    .sample_valid_in  (sample_valid),
    .tick_in          (tick),
`ifdef AUDIO_LOOP_VOLUME_EN
    .vol_in           (vol),
`endif
    .bram_wr_addr_out (wr_addr),
    .bram_wr_data_out (wr_data),
    .bram_we_out      (we),
    .bram_rd_addr_out (rd_addr),
    .bram_rd_data_in  (rd_data),
    .sample_out       (dut_sample),
    .sample_valid_out (dut_valid),
    .state_out        (state),
    .length_out       (length),
    .full_out         (full),
    .done_out         (done)
  );

  // Dual-port BRAM with two cycles from address to data.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_r1, rd_r2;
  always @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_r1 <= mem[rd_addr];
    rd_r2 <= rd_r1;
  end
  assign rd_data = rd_r2;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: mode (0 idle, 1 record, 2 play), take bookkeeping and scheduled outputs.
  typedef struct {
    int              due;
    logic [WIDTH-1:0] val;
  } pend_t;

  int               m_mode = 0;
  int               m_wr = 0;
  int               m_rd = 0;
  int               m_len = 0;
  bit               m_full = 0;
  bit               m_done = 0;
  logic [WIDTH-1:0] m_last = '0;
  logic [WIDTH-1:0] ref_mem [DEPTH];
  pend_t            pending[$];
  logic [WIDTH-1:0] obs_log[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
    rec_start    = 1'b0;
    play_start   = 1'b0;
    stop         = 1'b0;
    sample_valid = 1'b0;
    tick         = 1'b0;
  endtask

  task automatic checkPost(input string tag);
    bit exp_v;
    exp_v = (pending.size() > 0) && (pending[0].due == cyc);
    if (exp_v) begin
      m_last = pending[0].val;
      void'(pending.pop_front());
    end
    checkOutput({tag, "_valid"}, 32'(dut_valid), 32'(exp_v));
    checkOutput({tag, "_sample"}, 32'(dut_sample), 32'(m_last));
    checkOutput({tag, "_state"}, 32'(state), 32'(m_mode));
    checkOutput({tag, "_length"}, 32'(length), 32'(m_len));
    checkOutput({tag, "_full"}, 32'(full), 32'(m_full));
    checkOutput({tag, "_done"}, 32'(done), 32'(m_done));
    if (dut_valid === 1'b1) obs_log.push_back(dut_sample);
  endtask

  // One clock: check write/read ports against the inputs, advance the model, then check registered outputs.
  task automatic step(input string tag);
    bit               exp_we;
    logic [WIDTH-1:0] v;
    m_done = 0;
    if (rst) begin
      m_mode = 0; m_wr = 0; m_rd = 0; m_len = 0; m_full = 0; m_last = '0;
      pending.delete();
    end else begin
      exp_we = (m_mode == 1) && sample_valid;
      #1;
      checkOutput({tag, "_we"}, 32'(we), 32'(exp_we));
      if (exp_we) begin
        checkOutput({tag, "_wr_addr"}, 32'(wr_addr), 32'(m_wr));
        checkOutput({tag, "_wr_data"}, 32'(wr_data), 32'(sample));
        ref_mem[m_wr] = sample;
      end
      if (m_mode == 2 && tick && !stop && !rec_start)
        checkOutput({tag, "_rd_addr"}, 32'(rd_addr), 32'(m_rd));
      if (m_mode == 0) begin
        if (!stop && rec_start) begin
          m_mode = 1; m_wr = 0; m_full = 0;
        end else if (!stop && play_start && m_len > 0) begin
          m_mode = 2; m_rd = 0;
        end
      end else if (m_mode == 1) begin
        if (stop) begin
          m_len = m_wr + int'(exp_we);
          m_full = exp_we && (m_wr == DEPTH - 1);
          m_done = 1; m_mode = 0;
        end else if (rec_start) begin
          m_wr = 0; m_full = 0;
        end else if (exp_we) begin
          if (m_wr == DEPTH - 1) begin
            m_len = DEPTH; m_full = 1; m_done = 1; m_mode = 0;
          end else begin
            m_wr++;
          end
        end
      end else begin
        if (stop) begin
          pending.delete(); m_done = 1; m_mode = 0;
        end else if (rec_start) begin
          pending.delete(); m_mode = 1; m_wr = 0; m_full = 0;
        end else if (tick) begin
          v = ref_mem[m_rd];
`ifdef AUDIO_LOOP_VOLUME_EN
          v = v >> vol;
`endif
          pending.push_back('{cyc + READ_LATENCY, v});
          if (m_rd == m_len - 1) begin
            m_rd = 0;
            if (!loop_en) begin
              m_mode = 0; m_done = 1;
            end
          end else begin
            m_rd++;
          end
        end
      end
    end
    applyStimulus();
    checkPost(tag);
  endtask

  task automatic playTicks(input int n, input int gmin, input int gmax, input bit stop_after);
    for (int t = 0; t < n; t++) begin
      int g;
      g = int'($urandom_range(gmax, gmin));
      for (int j = 0; j < g - 1; j++) step("play_idle");
      tick = 1'b1;
      step("play_tick");
    end
    if (stop_after) begin
      stop = 1'b1;
      step("play_stop");
    end
    for (int j = 0; j < READ_LATENCY + 2; j++) step("play_drain");
  endtask

  initial begin
    // Reset
    step("reset");
    step("reset");
    rst = 1'b0;
    step("post_reset");
    checkOutput("reset_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("reset_rd_addr", 32'(rd_addr), 32'd0);
    checkOutput("reset_sample_out", 32'(dut_sample), 32'd0);

    // Playing an empty take is ignored
    play_start = 1'b1;
    step("play_empty");
    checkOutput("play_empty_state", 32'(state), 32'd0);

    // Nine samples into an eight-deep buffer: the ninth is dropped
    rec_start = 1'b1;
    step("full_start");
    for (int i = 0; i < 9; i++) begin
      sample = 8'($urandom);
      sample_valid = 1'b1;
      step("full_rec");
    end
    checkOutput("full_length", 32'(length), 32'd8);
    checkOutput("full_flag", 32'(full), 32'd1);

    // Record beats play when both start together
    rec_start = 1'b1;
    play_start = 1'b1;
    step("rec_over_play");
    checkOutput("rec_over_play_state", 32'(state), 32'd1);

    // Five-sample take, stop on the same cycle as the last write
    for (int i = 0; i < 5; i++) begin
      sample = 8'(8'h10 + i);
      sample_valid = 1'b1;
      stop = (i == 4);
      step("rec5");
    end
    checkOutput("rec5_length", 32'(length), 32'd5);
    checkOutput("rec5_done", 32'(done), 32'd1);
    checkOutput("rec5_full", 32'(full), 32'd0);
    step("rec5_after");
    checkOutput("rec5_done_cleared", 32'(done), 32'd0);

    // Single playback, one tick every ten cycles
    obs_log.delete();
    loop_en = 1'b0;
    play_start = 1'b1;
    step("play_once_start");
    playTicks(5, 10, 10, 1'b0);
    checkOutput("play_once_count", 32'(obs_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < obs_log.size(); i++)
      checkOutput("play_once_value", 32'(obs_log[i]), 32'(8'h10 + i));
    checkOutput("play_once_state", 32'(state), 32'd0);

    // Looped playback, thirteenth tick cut off by a stop one cycle later
    obs_log.delete();
    loop_en = 1'b1;
    play_start = 1'b1;
    step("play_loop_start");
    playTicks(13, 3, 3, 1'b1);
    checkOutput("play_loop_count", 32'(obs_log.size()), 32'd12);
    for (int i = 0; i < 12 && i < obs_log.size(); i++)
      checkOutput("play_loop_value", 32'(obs_log[i]), 32'(8'h10 + (i % 5)));

    // Random takes and tick spacing, including back-to-back ticks
    for (int it = 0; it < 4; it++) begin
      int n;
      bit stop_with_write;
      n = int'($urandom_range(7, 1));
      stop_with_write = 1'($urandom_range(1, 0));
      rec_start = 1'b1;
      step("rnd_rec_start");
      for (int i = 0; i < n; i++) begin
        sample = 8'($urandom);
        sample_valid = 1'b1;
        stop = stop_with_write && (i == n - 1);
        step("rnd_rec");
        if ($urandom_range(1, 0) == 1) step("rnd_rec_gap");
      end
      if (!stop_with_write) begin
        stop = 1'b1;
        step("rnd_rec_stop");
      end
      loop_en = 1'($urandom_range(1, 0));
      play_start = 1'b1;
      step("rnd_play_start");
      playTicks(12, 1, 3, 1'b1);
    end

    // Stop and record together during playback: stop wins
    loop_en = 1'b1;
    play_start = 1'b1;
    step("sr_play_start");
    tick = 1'b1;
    step("sr_tick");
    stop = 1'b1;
    rec_start = 1'b1;
    step("sr_stop_rec");
    checkOutput("sr_state", 32'(state), 32'd0);
    checkOutput("sr_done", 32'(done), 32'd1);
    for (int j = 0; j < 3; j++) step("sr_drain");

    // Record start during playback flushes the read in flight
    play_start = 1'b1;
    step("pr_play_start");
    tick = 1'b1;
    step("pr_tick");
    rec_start = 1'b1;
    step("pr_rec");
    checkOutput("pr_state", 32'(state), 32'd1);
    for (int j = 0; j < 3; j++) step("pr_drain");

`ifdef AUDIO_LOOP_VOLUME_EN
    // Attenuated playback
    stop = 1'b1;
    step("vol_stop");
    vol = 3'd2;
    rec_start = 1'b1;
    step("vol_rec_start");
    sample = 8'hF0;
    sample_valid = 1'b1;
    stop = 1'b1;
    step("vol_rec");
    obs_log.delete();
    loop_en = 1'b0;
    play_start = 1'b1;
    step("vol_play_start");
    playTicks(1, 2, 2, 1'b0);
    checkOutput("vol_count", 32'(obs_log.size()), 32'd1);
    if (obs_log.size() > 0) checkOutput("vol_value", 32'(obs_log[0]), 32'h3C);
    vol = 3'd0;
`endif

    // Reset in the middle of a recording
    stop = 1'b1;
    step("mid_stop");
    rec_start = 1'b1;
    step("mid_rec_start");
    for (int i = 0; i < 3; i++) begin
      sample = 8'($urandom);
      sample_valid = 1'b1;
      step("mid_rec");
    end
    sample = '0;
    rst = 1'b1;
    step("mid_reset");
    rst = 1'b0;
    #1;
    checkOutput("mid_reset_we", 32'(we), 32'd0);
    checkOutput("mid_reset_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("mid_reset_rd_addr", 32'(rd_addr), 32'd0);
    checkOutput("mid_reset_length", 32'(length), 32'd0);
    play_start = 1'b1;
    step("mid_play_ignored");
    checkOutput("mid_play_state", 32'(state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
